// File: rtl/gsel_ctrl.sv
// Game-select controller: decodes a keyed 68k port write sequence and sequences a
// game switch as a GSEL blank window, then the new index, then a console reset pulse.
module gsel_ctrl #(
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned RST_CYCLES   = 12000,
  parameter int unsigned TIMEOUT      = 12000
) (
  input  logic       CLK_12M,
  input  logic       nRESET,
  input  logic       nPORTWEL,
  input  logic [2:0] M68K_ADDR,
  input  logic [7:0] M68K_DATA,
  output logic [7:0] GSEL,
  output logic       nSYS_RST,
  output logic       BUSY
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StKey1  = 3'd1;
  localparam logic [2:0] StKey2  = 3'd2;
  localparam logic [2:0] StBlank = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;

  localparam logic [15:0] BlankLast   = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] HoldLast    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  localparam logic [7:0] Key1Val = 8'h5A;
  localparam logic [7:0] Key2Val = 8'hA5;

  logic       sync1_q, sync2_q, sync3_q;
  logic       wev_q;
  logic [2:0] cap_addr_q;
  logic [7:0] cap_data_q;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  next_q, next_d;
  logic [7:0]  gsel_q, gsel_d;
  logic        nsys_rst_q, nsys_rst_d;
  logic        busy_q, busy_d;

  logic key_wr;
  logic in_switch;

  // Strobe synchroniser; idles high so reset never manufactures a write event.
  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
      wev_q   <= 1'b0;
    end else begin
      sync1_q <= nPORTWEL;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      wev_q   <= sync2_q & ~sync3_q;
    end
  end

  // Bus is stable while the strobe is low; capture freezes once the strobe rises.
  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      cap_addr_q <= 3'd0;
      cap_data_q <= 8'h00;
    end else if (!sync2_q) begin
      cap_addr_q <= M68K_ADDR;
      cap_data_q <= M68K_DATA;
    end
  end

  assign key_wr = wev_q && (cap_addr_q == 3'd0 || cap_addr_q == 3'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    next_d  = next_q;
    gsel_d  = gsel_q;
    case (state_q)
      StIdle: begin
        cnt_d = 16'd0;
        if (key_wr && cap_addr_q == 3'd0 && cap_data_q == Key1Val) begin
          state_d = StKey1;
        end
      end
      StKey1: begin
        cnt_d = cnt_q + 16'd1;
        if (key_wr) begin
          cnt_d   = 16'd0;
          state_d = (cap_addr_q == 3'd0 && cap_data_q == Key2Val) ? StKey2 : StIdle;
        end else if (cnt_q == TimeoutLast) begin
          cnt_d   = 16'd0;
          state_d = StIdle;
        end
      end
      StKey2: begin
        cnt_d = cnt_q + 16'd1;
        if (key_wr) begin
          cnt_d = 16'd0;
          if (cap_addr_q == 3'd1) begin
            next_d  = cap_data_q;
            gsel_d  = 8'h00;
            state_d = StBlank;
          end else begin
            state_d = StIdle;
          end
        end else if (cnt_q == TimeoutLast) begin
          cnt_d   = 16'd0;
          state_d = StIdle;
        end
      end
      StBlank: begin
        if (cnt_q == BlankLast) begin
          cnt_d   = 16'd0;
          gsel_d  = next_q;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = 16'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch on the same edge as it.
  assign in_switch  = (state_d == StBlank) || (state_d == StHold);
  assign nsys_rst_d = ~in_switch;
  assign busy_d     = in_switch;

  always_ff @(posedge CLK_12M or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= StIdle;
      cnt_q      <= 16'd0;
      next_q     <= 8'h00;
      gsel_q     <= 8'h00;
      nsys_rst_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      next_q     <= next_d;
      gsel_q     <= gsel_d;
      nsys_rst_q <= nsys_rst_d;
      busy_q     <= busy_d;
    end
  end

  assign GSEL     = gsel_q;
  assign nSYS_RST = nsys_rst_q;
  assign BUSY     = busy_q;

endmodule

// File: doc/gsel_ctrl.md
# gsel_ctrl

Game-select controller on the PROG CPLD, upstream of the CHA CPLD. It decodes a keyed write sequence on the 68k cartridge port space and holds the 8-bit game index GSEL that the CHA CPLD uses for C-ROM/M-ROM bank lookup. On a change of game it sequences the switch: GSEL=0 (CHA pseudo-reset) for a blank window, then the new index, then a console reset pulse.

## Interface
Parameters:
- BLANK_CYCLES, 16: CLK_12M cycles GSEL is forced to 0 before the new index is applied.
- RST_CYCLES, 12000: CLK_12M cycles nSYS_RST is held low (1 ms).
- TIMEOUT, 12000: maximum CLK_12M cycles allowed between consecutive key writes.

Ports (one clock; reset is asynchronous and active-low):
- CLK_12M, in, 1: system clock.
- nRESET, in, 1: asynchronous active-low reset.
- nPORTWEL, in, 1: 68k lower-byte port write strobe, active-low, asynchronous to CLK_12M.
- M68K_ADDR, in, 3: 68k address [3:1] within port space.
- M68K_DATA, in, 8: 68k data [7:0].
- GSEL, out, 8: game index to the CHA CPLD.
- nSYS_RST, out, 1: console reset request, active-low.
- BUSY, out, 1: high in the BLANK or HOLD state.

## Operation
- Strobe sync: 2-flop synchroniser on nPORTWEL, plus a third flop for edge detect. A write event (WEV) is a rising edge of the synchronised strobe.
- Data/address capture: M68K_ADDR and M68K_DATA are registered every cycle while the synchronised strobe is low. At WEV, the last captured pair is used.
- Offsets: ADDR=0 is the key register. ADDR=1 is the select register. Other offsets are ignored (no state change, timer not reset).
- States: IDLE, KEY1, KEY2, BLANK, HOLD.
  - IDLE: WEV with (0, 0x5A) goes to KEY1. All other writes stay in IDLE.
  - KEY1: WEV with (0, 0xA5) goes to KEY2. Any other write to offset 0 or 1 goes to IDLE.
  - KEY2: WEV with (1, D) latches NEXT=D and goes to BLANK. Any other write to offset 0 or 1 goes to IDLE.
  - In KEY1 and KEY2, the timer increments each cycle and resets on every state advance. When it reaches TIMEOUT-1 with no valid write, the state returns to IDLE.
  - BLANK: GSEL=0 and nSYS_RST=0 for BLANK_CYCLES cycles. GSEL then loads NEXT and the state goes to HOLD.
  - HOLD: nSYS_RST=0 for RST_CYCLES cycles, then goes to IDLE with nSYS_RST=1.
- Writes during BLANK or HOLD are ignored, including key writes. They do not queue.
- NEXT=0 is legal (return to menu). The full sequence still runs.
- NEXT equal to the current GSEL still runs the full sequence.
- Counters are 16 bits wide. Parameters must be at least 1 and at most 65535.

## Timing
- Reset values: state IDLE, GSEL=8'h00, nSYS_RST=1, BUSY=0, counters 0, NEXT=0.
- nRESET assertion mid-sequence forces the reset values immediately (asynchronous). After release, the block stays in IDLE with no pending switch.
- WEV latency: 3 CLK_12M rising edges after the pin goes high (2 sync edges + 1 edge-detect edge). The state register updates on the following edge (edge E).
- Commit: at edge E, the state becomes BLANK, and GSEL=0, nSYS_RST=0 and BUSY=1 all become visible.
- GSEL=NEXT becomes visible at E+BLANK_CYCLES. nSYS_RST and BUSY return to 1/0 at E+BLANK_CYCLES+RST_CYCLES.
- nSYS_RST is low for exactly BLANK_CYCLES+RST_CYCLES cycles. GSEL changes at most twice per commit and is glitch-free (registered output).
- Strobe low pulses shorter than 2 CLK_12M periods may be missed. The 68k minimum write pulse exceeds this.

## Test plan
Use BLANK_CYCLES=4, RST_CYCLES=8, TIMEOUT=20.
- Write (0,5A), (0,A5), (1,07). Required: GSEL goes 00→00 (4 cycles)→07. nSYS_RST is low for exactly 12 cycles starting at commit+0. BUSY mirrors the low window.
- Write (0,5A), (0,33), (1,07). Required: no commit, GSEL is unchanged, state is IDLE after the second write, and nSYS_RST stays 1.
- Write (0,5A), wait 25 cycles, then (0,A5), (1,07). Required: the timeout returns the state to IDLE and no commit occurs. A subsequent full valid sequence then commits 07.
- Commit 07, then write a full sequence selecting 09 during HOLD. Required: the second sequence is ignored and GSEL stays 07 after HOLD. A fresh sequence after BUSY falls commits 09.
- Commit 07, then assert nRESET during BLANK. Required: GSEL=00, nSYS_RST=1 and BUSY=0 immediately (same cycle, asynchronous), and the state is IDLE after release.
- Write (0,5A), (3,FF), (0,A5), (1,00) starting from GSEL=07. Required: the offset-3 write is ignored, and the sequence commits GSEL=00 with the full 12-cycle nSYS_RST pulse.
